// File: rtl/muldiv_unit_if.sv
// muldiv_unit request/response bundle
// master drives requests, slave returns results
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start,
    output funct3,
    output rs1,
    output rs2,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  funct3,
    input  rs1,
    input  rs2,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit
// 32-cycle shift-add / restoring divide
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [5:0]      r_cnt;
  logic [2:0]      r_op;
  logic            r_neg;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_result;

  logic            w_div;
  logic            w_sa;
  logic            w_sb;
  logic            w_neg;
  logic [XLEN-1:0] w_ma;
  logic [XLEN-1:0] w_mb;
  logic            w_zero;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_trial;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_fin;

  // Decode operands and fast-path cases at accept
  always_comb begin
    w_div  = bus.funct3[2];
    w_sa   = 1'b0;
    w_sb   = 1'b0;
    unique case (1'b1)
      bus.funct3 == 3'd1: begin
        w_sa = bus.rs1[XLEN-1];
        w_sb = bus.rs2[XLEN-1];
      end
      bus.funct3 == 3'd2: begin
        w_sa = bus.rs1[XLEN-1];
      end
      bus.funct3 == 3'd4,
      bus.funct3 == 3'd6: begin
        w_sa = bus.rs1[XLEN-1];
        w_sb = bus.rs2[XLEN-1];
      end
      default: begin
        w_sa = 1'b0;
      end
    endcase
    w_ma   = w_sa ? -bus.rs1 : bus.rs1;
    w_mb   = w_sb ? -bus.rs2 : bus.rs2;
    // REM follows the dividend sign only
    w_neg  = (bus.funct3 == 3'd6) ? w_sa
                                  : (w_sa ^ w_sb);
    w_zero = (bus.rs2 == '0);
    w_ovf  = (bus.rs1 == 32'h8000_0000)
           & (bus.rs2 == 32'hFFFF_FFFF)
           & ~bus.funct3[0];
    w_fast = w_div & (w_zero | w_ovf);
    if (w_zero) begin
      w_fast_res = bus.funct3[1] ? bus.rs1
                                 : 32'hFFFF_FFFF;
    end else begin
      w_fast_res = bus.funct3[1] ? 32'h0
                                 : 32'h8000_0000;
    end
  end

  // One iteration step and final sign fix-up
  always_comb begin
    w_sum   = {1'b0, r_hi}
            + (r_lo[0] ? {1'b0, r_b} : '0);
    w_trial = {r_hi, r_lo[XLEN-1]}
            - {1'b0, r_b};
    w_prod   = {r_hi, r_lo};
    w_prod_s = r_neg ? -w_prod : w_prod;
    w_quo_s  = r_neg ? -r_lo : r_lo;
    w_rem_s  = r_neg ? -r_hi : r_hi;
    case (r_op)
      3'd0:    w_fin = w_prod_s[XLEN-1:0];
      3'd1,
      3'd2,
      3'd3:    w_fin = w_prod_s[2*XLEN-1:XLEN];
      3'd4,
      3'd5:    w_fin = w_quo_s;
      default: w_fin = w_rem_s;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start)
          w_next = w_fast ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (r_cnt == 6'd31) w_next = S_FIN;
      end
      S_FIN:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs from current state
  always_comb begin
    bus.busy   = (r_state == S_CALC)
               | (r_state == S_FIN);
    bus.done   = (r_state == S_DONE);
    bus.result = r_result;
  end

  // Datapath: latch, iterate, finish
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op  <= bus.funct3;
            r_neg <= w_neg;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= w_div ? w_ma : w_mb;
            r_b   <= w_div ? w_mb : w_ma;
            if (w_fast) r_result <= w_fast_res;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 6'd1;
          if (!r_op[2]) begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
          end else if (!w_trial[XLEN]) begin
            r_hi <= w_trial[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], 1'b1};
          end else begin
            r_hi <= {r_hi[XLEN-2:0], r_lo[XLEN-1]};
            r_lo <= {r_lo[XLEN-2:0], 1'b0};
          end
        end
        S_FIN: begin
          r_cnt    <= '0;
          r_result <= w_fin;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit
// scoreboard of expected results per accept
module tb_muldiv_unit;

  logic clk;
  logic rst;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] model(
    input logic [2:0]  f,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin
        p = {32'h0, a} * {32'h0, b};
        return p[31:0];
      end
      3'd1: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        return p[63:32];
      end
      3'd2: begin
        p = {{32{a[31]}}, a} * {32'h0, b};
        return p[63:32];
      end
      3'd3: begin
        p = {32'h0, a} * {32'h0, b};
        return p[63:32];
      end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic run_op(
    input string       name,
    input logic [2:0]  f,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] exp_res,
    input int          exp_lat
  );
    int lat;
    bit got;
    int busy_bad;
    int stab_bad;
    logic [31:0] held;
    logic [31:0] want;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.rs1    = a;
    bus.rs2    = b;
    held       = bus.result;
    exp_q.push_back(exp_res);
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.rs1    = $urandom;
    bus.rs2    = $urandom;
    lat = 0;
    got = 1'b0;
    busy_bad = 0;
    stab_bad = 0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (bus.done) begin
        got = 1'b1;
        if (bus.busy) busy_bad++;
      end else begin
        if (bus.busy !== (exp_lat > 1))
          busy_bad++;
        if (bus.result !== held) stab_bad++;
      end
    end
    want = exp_q.pop_front();
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL %s timeout: no done in %0d cyc",
               name, lat);
    end else begin
      if (lat !== exp_lat) begin
        n_err++;
        $display("FAIL %s latency: got %0d want %0d",
                 name, lat, exp_lat);
      end
      n_vec++;
      if (bus.result !== want) begin
        n_err++;
        $display("FAIL %s result: got %h want %h",
                 name, bus.result, want);
      end
    end
    n_vec++;
    if (busy_bad !== 0) begin
      n_err++;
      $display("FAIL %s busy: %0d bad cyc want 0",
               name, busy_bad);
    end
    n_vec++;
    if (stab_bad !== 0) begin
      n_err++;
      $display("FAIL %s stable: %0d changes want 0",
               name, stab_bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset busy: got %b want 0",
               bus.busy);
    end
    n_vec++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset done: got %b want 0",
               bus.done);
    end
    n_vec++;
    if (bus.result !== 32'h0) begin
      n_err++;
      $display("FAIL reset result: got %h want 0",
               bus.result);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD,
           32'hFFFF_FFEB, 34);
    run_op("mulh", 3'd1, 32'd7, 32'hFFFF_FFFD,
           32'hFFFF_FFFF, 34);
    run_op("mulhu", 3'd3, 32'd7, 32'hFFFF_FFFD,
           32'h0000_0006, 34);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("mulh_min", 3'd1, 32'h8000_0000,
           32'h8000_0000, 32'h4000_0000, 34);
  endtask

  task automatic test_div();
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFD, 34);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 34);
    run_op("divu", 3'd5, 32'd100, 32'd7,
           32'd14, 34);
    run_op("remu", 3'd7, 32'd100, 32'd7,
           32'd2, 34);
  endtask

  task automatic test_fast_path();
    run_op("divu_z", 3'd5, 32'd5, 32'd0,
           32'hFFFF_FFFF, 1);
    run_op("rem_z", 3'd6, 32'd5, 32'd0,
           32'd5, 1);
    run_op("div_ovf", 3'd4, 32'h8000_0000,
           32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'd6, 32'h8000_0000,
           32'hFFFF_FFFF, 32'h0, 1);
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = (i == 3) ? 32'h0 : $urandom;
      run_op("rand", f, a, b, model(f, a, b),
             (f[2] && b == 0) ? 1 : 34);
    end
  endtask

  task automatic test_reset_midcalc();
    int dn;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd4;
    bus.rs1    = 32'd1000;
    bus.rs2    = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst busy: got %b want 0",
               bus.busy);
    end
    n_vec++;
    if (bus.result !== 32'h0) begin
      n_err++;
      $display("FAIL midrst result: got %h want 0",
               bus.result);
    end
    bus.start  = 1'b1;
    bus.funct3 = 3'd0;
    bus.rs1    = 32'd9;
    bus.rs2    = 32'd9;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) dn++;
    end
    n_vec++;
    if (dn !== 0) begin
      n_err++;
      $display("FAIL midrst activity: %0d cyc want 0",
               dn);
    end
    run_op("mul_after_rst", 3'd0, 32'd3, 32'd4,
           32'd12, 34);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int pulses;
    int last;
    int stab_bad;
    bit acc_next;
    bit seen;
    logic [31:0] held;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    cyc = 0;
    pulses = 0;
    last = 0;
    stab_bad = 0;
    acc_next = 1'b1;
    held = bus.result;
    while (pulses < 4 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      seen = bus.done;
      if (seen) begin
        n_vec++;
        if (bus.result !== exp_q[0]) begin
          n_err++;
          $display("FAIL b2b result: got %h want %h",
                   bus.result, exp_q[0]);
        end
        void'(exp_q.pop_front());
        if (pulses > 0) begin
          n_vec++;
          if (cyc - last !== 35) begin
            n_err++;
            $display("FAIL b2b period: got %0d want 35",
                     cyc - last);
          end
        end
        last = cyc;
        held = bus.result;
        pulses++;
      end else if (bus.result !== held) begin
        stab_bad++;
      end
      if (pulses >= 4) break;
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      if (b == 0) b = 32'd1;
      if (b == 32'hFFFF_FFFF) b = 32'd3;
      bus.start  = 1'b1;
      bus.funct3 = f;
      bus.rs1    = a;
      bus.rs2    = b;
      if (acc_next) exp_q.push_back(model(f, a, b));
      acc_next = seen;
    end
    bus.start = 1'b0;
    n_vec++;
    if (pulses !== 4) begin
      n_err++;
      $display("FAIL b2b pulses: got %0d want 4",
               pulses);
    end
    n_vec++;
    if (stab_bad !== 0) begin
      n_err++;
      $display("FAIL b2b stable: %0d changes want 0",
               stab_bad);
    end
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL b2b queue: %0d left want 0",
               exp_q.size());
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = 3'd0;
    bus.rs1    = 32'h0;
    bus.rs2    = 32'h0;
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_random();
    test_reset_midcalc();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
